// File: rtl/bar_pkg.sv
// Shared constants and types for the spectrum bar display path.
// The colour mapper imports this package to reuse the bar-height array type.
package bar_pkg;

    localparam int NUM_BARS   = 10;
    localparam int BAR_H_W    = 10;
    localparam int SCREEN_H   = 480;
    localparam int MAX_HEIGHT = 470;

    typedef logic [NUM_BARS-1:0][BAR_H_W-1:0] bar_heights_t;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_COMMIT  = 2'd1,
        ST_PUBLISH = 2'd2
    } bar_state_e;

    // Top pixel row of a bar, as the colour mapper draws it.
    function automatic logic [BAR_H_W-1:0] bar_top_row(input logic [BAR_H_W-1:0] height);
        return BAR_H_W'(SCREEN_H) - height;
    endfunction

endpackage

// File: rtl/bar_decay_unit.sv
// Next shadow height for one bar: the larger of the fresh peak and the
// previous height after fall-off, floored at zero.
module bar_decay_unit #(
    parameter int W     = bar_pkg::BAR_H_W,
    parameter int DECAY = 4
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] shadow_i,
    output logic [W-1:0] level_o
);

    logic [W-1:0] decayed;

    assign decayed = (shadow_i > W'(DECAY)) ? (shadow_i - W'(DECAY)) : '0;
    assign level_o = (acc_i > decayed) ? acc_i : decayed;

endmodule

// File: rtl/bar_level_tracker.sv
// Per-frame peak capture of spectrum bins into bar heights, with decay and
// an atomic publish of all bars once per frame tick.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_ACCUM   | bins update band peaks; frame_tick starts a commit pass
// ST_COMMIT  | one bar per cycle: shadow = max(peak, decayed shadow), peak cleared
// ST_PUBLISH | shadow copied to BarHeight, heights_valid pulsed
module bar_level_tracker #(
    parameter int NUM_BARS      = bar_pkg::NUM_BARS,
    parameter int BINS_PER_BAND = 16,
    parameter int MAG_SHIFT     = 6,
    parameter int DECAY         = 4,
    parameter int MAX_HEIGHT    = bar_pkg::MAX_HEIGHT
) (
    input  logic                                       Clk,
    input  logic                                       Reset_n,
    input  logic                                       frame_tick,
    input  logic                                       bin_valid,
    input  logic [8:0]                                 bin_index,
    input  logic [15:0]                                bin_mag,
    output logic [NUM_BARS-1:0][bar_pkg::BAR_H_W-1:0]  BarHeight,
    output logic                                       heights_valid,
    output logic                                       overrun
);

    import bar_pkg::*;

    localparam int HW         = bar_pkg::BAR_H_W;
    localparam int IDX_W      = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int BAND_SHIFT = $clog2(BINS_PER_BAND);

    bar_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NUM_BARS-1:0][HW-1:0] acc_q, acc_d;
    logic [NUM_BARS-1:0][HW-1:0] shadow_q, shadow_d;
    logic [NUM_BARS-1:0][HW-1:0] bar_q, bar_d;
    logic valid_q, valid_d;
    logic overrun_q, overrun_d;

    logic [8:0]    band;
    logic          bin_hit;
    logic [15:0]   mag_shifted;
    logic [HW-1:0] lvl;
    logic          commit_en;
    logic          publish_en;
    logic [HW-1:0] commit_level;

    assign band        = bin_index >> BAND_SHIFT;
    assign bin_hit     = bin_valid && (band < 9'(NUM_BARS));
    assign mag_shifted = bin_mag >> MAG_SHIFT;
    assign lvl         = (mag_shifted > 16'(MAX_HEIGHT)) ? HW'(MAX_HEIGHT) : mag_shifted[HW-1:0];

    bar_decay_unit #(
        .W     (HW),
        .DECAY (DECAY)
    ) u_decay (
        .acc_i    (acc_q[idx_q]),
        .shadow_i (shadow_q[idx_q]),
        .level_o  (commit_level)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        commit_en  = 1'b0;
        publish_en = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (frame_tick) begin
                    state_d = ST_COMMIT;
                    idx_d   = '0;
                end
            end
            ST_COMMIT: begin
                commit_en = 1'b1;
                if (idx_q == IDX_W'(NUM_BARS - 1)) begin
                    state_d = ST_PUBLISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_PUBLISH: begin
                publish_en = 1'b1;
                state_d    = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // A bin landing on the bar being committed seeds the next frame's peak.
    always_comb begin
        acc_d = acc_q;
        for (int b = 0; b < NUM_BARS; b++) begin
            if (commit_en && (idx_q == IDX_W'(b))) begin
                acc_d[b] = (bin_hit && (band == 9'(b))) ? lvl : '0;
            end else if (bin_hit && (band == 9'(b)) && (lvl > acc_q[b])) begin
                acc_d[b] = lvl;
            end
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (commit_en) begin
            shadow_d[idx_q] = commit_level;
        end
    end

    assign bar_d     = publish_en ? shadow_q : bar_q;
    assign valid_d   = publish_en;
    assign overrun_d = overrun_q | (frame_tick && (state_q != ST_ACCUM));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_ACCUM;
            idx_q     <= '0;
            acc_q     <= '0;
            shadow_q  <= '0;
            bar_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            shadow_q  <= shadow_d;
            bar_q     <= bar_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign BarHeight     = bar_q;
    assign heights_valid = valid_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_bar_level_tracker.sv
// Scoreboard bench for bar_level_tracker: a frame-level reference model
// predicts each publication; a monitor checks pulses, latency, hold and overrun.
module tb_bar_level_tracker;

    localparam int NB   = 10;
    localparam int BPB  = 16;
    localparam int MSH  = 6;
    localparam int DEC  = 4;
    localparam int MAXH = 470;

    logic             Clk        = 1'b0;
    logic             Reset_n    = 1'b0;
    logic             frame_tick = 1'b0;
    logic             bin_valid  = 1'b0;
    logic [8:0]       bin_index  = '0;
    logic [15:0]      bin_mag    = '0;
    logic [NB-1:0][9:0] BarHeight;
    logic             heights_valid;
    logic             overrun;

    bar_level_tracker #(
        .NUM_BARS      (NB),
        .BINS_PER_BAND (BPB),
        .MAG_SHIFT     (MSH),
        .DECAY         (DEC),
        .MAX_HEIGHT    (MAXH)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_tick    (frame_tick),
        .bin_valid     (bin_valid),
        .bin_index     (bin_index),
        .bin_mag       (bin_mag),
        .BarHeight     (BarHeight),
        .heights_valid (heights_valid),
        .overrun       (overrun)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [NB-1:0][9:0] bars;
        int                 due;
    } exp_t;

    exp_t q[$];

    // Frame-level reference: current-frame peaks, peaks already belonging to
    // the next frame, and the displayed-height memory that decays.
    int acc_m[NB];
    int nxt_m[NB];
    int shd_m[NB];
    bit busy    = 1'b0;
    int tick_n  = 0;
    int ovr_due = -1;

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            acc_m[i] = 0;
            nxt_m[i] = 0;
            shd_m[i] = 0;
        end
        busy    = 1'b0;
        ovr_due = -1;
    endtask

    task automatic step(input bit tk, input bit bv, input int bi, input int bm);
        int   b;
        int   lv;
        int   dec;
        int   n;
        exp_t e;
        @(posedge Clk);
        #1;
        frame_tick = tk;
        bin_valid  = bv;
        bin_index  = 9'(bi);
        bin_mag    = 16'(bm);
        n = cyc;
        if (bv) begin
            b  = bi / BPB;
            lv = bm >> MSH;
            if (lv > MAXH) lv = MAXH;
            if (b < NB) begin
                // Bar b is committed in the cycle tick_n+1+b; bins from then on
                // belong to the following frame.
                if (busy && n >= tick_n + 1 + b) begin
                    if (lv > nxt_m[b]) nxt_m[b] = lv;
                end else begin
                    if (lv > acc_m[b]) acc_m[b] = lv;
                end
            end
        end
        if (tk) begin
            if (busy) begin
                if (ovr_due < 0) ovr_due = n + 1;
            end else begin
                busy   = 1'b1;
                tick_n = n;
            end
        end
        if (busy && n == tick_n + 1 + NB) begin
            for (int i = 0; i < NB; i++) begin
                dec = (shd_m[i] > DEC) ? shd_m[i] - DEC : 0;
                shd_m[i] = (acc_m[i] > dec) ? acc_m[i] : dec;
                acc_m[i] = nxt_m[i];
                nxt_m[i] = 0;
                e.bars[i] = 10'(shd_m[i]);
            end
            e.due = n + 1;
            q.push_back(e);
            busy = 1'b0;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic wait_frame();
        int guard;
        guard = 0;
        while (busy && guard < 4 * NB) begin
            step(1'b0, 1'b0, 0, 0);
            guard++;
        end
        step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        bin_valid  = 1'b0;
        model_clear();
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic expect_bar(input int i, input int v, input string nm);
        n_cmp++;
        if (BarHeight[i] !== 10'(v)) begin
            n_bad++;
            $display("FAIL %s: BarHeight[%0d] got %0d expected %0d", nm, i, BarHeight[i], v);
        end
    endtask

    task automatic expect_bit(input logic got, input logic want, input string nm);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, got, want);
        end
    endtask

    // Monitor: every heights_valid pops one prediction; otherwise outputs hold.
    initial begin : monitor
        logic [NB-1:0][9:0] held;
        exp_t e;
        logic ovr_exp;
        held = '0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                held = '0;
                q.delete();
                continue;
            end
            ovr_exp = (ovr_due >= 0 && cyc >= ovr_due) ? 1'b1 : 1'b0;
            n_cmp++;
            if (overrun !== ovr_exp) begin
                n_bad++;
                $display("FAIL overrun cyc=%0d: got %b expected %b", cyc, overrun, ovr_exp);
            end
            if (q.size() > 0 && cyc > q[0].due) begin
                e = q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_pulse: no heights_valid at cyc %0d (now %0d)", e.due, cyc);
            end
            if (heights_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: heights_valid=1 at cyc %0d, none predicted", cyc);
                end else begin
                    e = q.pop_front();
                    n_cmp++;
                    if (cyc != e.due) begin
                        n_bad++;
                        $display("FAIL latency: pulse at cyc %0d expected cyc %0d", cyc, e.due);
                    end
                    for (int i = 0; i < NB; i++) begin
                        n_cmp++;
                        if (BarHeight[i] !== e.bars[i]) begin
                            n_bad++;
                            $display("FAIL publish bar %0d cyc=%0d: got %0d expected %0d",
                                     i, cyc, BarHeight[i], e.bars[i]);
                        end
                    end
                    held = e.bars;
                end
            end else begin
                n_cmp++;
                if (BarHeight !== held) begin
                    n_bad++;
                    $display("FAIL hold cyc=%0d: got %h expected %h", cyc, BarHeight, held);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int dv[4];
        int gap;
        bit tk;
        bit bv;
        int bi;
        int bm;
        dv = '{11, 7, 3, 0};
        model_clear();
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        expect_bit(heights_valid, 1'b0, "reset_valid");
        expect_bit(overrun, 1'b0, "reset_overrun");
        for (int i = 0; i < NB; i++) expect_bar(i, 0, "reset_bars");

        // Reset in the middle of a commit pass must publish nothing.
        step(1'b0, 1'b1, 20, 2000);
        idle(2);
        step(1'b1, 1'b0, 0, 0);
        idle(3);
        do_reset();
        idle(2);
        step(1'b1, 1'b0, 0, 0);
        wait_frame();
        for (int i = 0; i < NB; i++) expect_bar(i, 0, "post_reset_zero");

        // Scaling and decay.
        step(1'b0, 1'b1, 0, 1000);
        step(1'b1, 1'b0, 0, 0);
        wait_frame();
        expect_bar(0, 15, "scale");
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 0, 0);
            wait_frame();
            expect_bar(0, dv[k], "decay");
        end

        // Saturation, banding and out-of-range bins.
        step(1'b0, 1'b1, 37, 16'hFFFF);
        step(1'b1, 1'b0, 0, 0);
        wait_frame();
        expect_bar(2, 470, "saturate");
        expect_bar(0, 0, "saturate_other");
        step(1'b0, 1'b1, 160, 16'hFFFF);
        step(1'b1, 1'b0, 0, 0);
        wait_frame();
        expect_bar(2, 466, "dropped_bin_decay");

        // Bin collides with the commit of its own bar.
        step(1'b1, 1'b0, 0, 0);
        idle(3);
        step(1'b0, 1'b1, 48, 640);
        wait_frame();
        expect_bar(3, 0, "collision_this_frame");
        step(1'b1, 1'b0, 0, 0);
        wait_frame();
        expect_bar(3, 10, "collision_next_frame");

        // Peak hold within one frame.
        step(1'b0, 1'b1, 48, 640);
        step(1'b0, 1'b1, 50, 3200);
        step(1'b1, 1'b0, 0, 0);
        wait_frame();
        expect_bar(3, 50, "peak_hold");

        // Tick too soon after the previous one.
        expect_bit(overrun, 1'b0, "overrun_before");
        step(1'b1, 1'b0, 0, 0);
        idle(4);
        step(1'b1, 1'b0, 0, 0);
        wait_frame();
        idle(2);
        expect_bit(overrun, 1'b1, "overrun_after");

        // Randomised traffic.
        gap = 3;
        for (int k = 0; k < 800; k++) begin
            tk = (gap == 0);
            if (tk) gap = $urandom_range(NB - 2, 25);
            else gap--;
            bv = ($urandom_range(0, 3) != 0);
            bi = $urandom_range(0, 175);
            case ($urandom_range(0, 2))
                0:       bm = $urandom_range(0, 1023);
                1:       bm = $urandom_range(0, 32767);
                default: bm = $urandom_range(0, 65535);
            endcase
            step(tk, bv, bi, bm);
        end
        idle(NB + 4);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions never published, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
